// File: rtl/tx_data_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : tx_data_buffer_if
//  Purpose  : Bundles the run-control, BRAM read-module and output stream
//             signals of tx_data_buffer. The master modport is the buffer
//             itself; the slave modport is its surrounding environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface tx_data_buffer_if #(
    parameter int DATA_BITS    = 512,
    parameter int ADDRESS_BITS = 10
);
    // Run control
    logic                    start;
    logic [ADDRESS_BITS-1:0] base_addr;
    logic [ADDRESS_BITS:0]   word_count;
    logic                    busy;
    logic                    done;

    // BRAM read module
    logic                    start_rd_en;
    logic [ADDRESS_BITS-1:0] address_input;
    logic [DATA_BITS-1:0]    fifo_tx_data;

    // Output stream
    logic [DATA_BITS-1:0]    m_data;
    logic                    m_valid;
    logic                    m_last;
    logic                    m_ready;

    modport master (
        input  start, base_addr, word_count, fifo_tx_data, m_ready,
        output busy, done, start_rd_en, address_input, m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, word_count, fifo_tx_data, m_ready,
        input  busy, done, start_rd_en, address_input, m_data, m_valid, m_last
    );
endinterface
`default_nettype wire

// File: rtl/tx_data_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tx_data_buffer
//  Purpose  : Issues a run of consecutive BRAM word addresses, tags returned
//             words through a fixed-latency valid pipeline, queues them in a
//             credit-protected FIFO and streams them out with a last marker.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_data_buffer #(
    parameter int DATA_BITS    = 512,
    parameter int ADDRESS_BITS = 10,
    parameter int FIFO_DEPTH   = 16,
    parameter int RD_LATENCY   = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    tx_data_buffer_if.master bus
);

    localparam int c_FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int c_FCNT_W  = c_FIFO_AW + 1;
    localparam int c_INF_W   = $clog2(RD_LATENCY) + 1;

    localparam logic [ADDRESS_BITS:0]   c_CNT_ONE  = (ADDRESS_BITS+1)'(1);
    localparam logic [ADDRESS_BITS-1:0] c_ADDR_ONE = ADDRESS_BITS'(1);
    localparam logic [c_FIFO_AW-1:0]    c_PTR_ONE  = c_FIFO_AW'(1);
    localparam logic [c_FCNT_W-1:0]     c_FCNT_ONE = c_FCNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Control state
    state_t                  state_q;
    logic [ADDRESS_BITS:0]   remaining_q;
    logic [ADDRESS_BITS:0]   word_count_q;
    logic [ADDRESS_BITS-1:0] next_addr_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rd_en_q;

    // Valid pipeline: bit 0 travels alongside the address it tags
    logic [RD_LATENCY-1:0]   vld_sr_q;
    logic [RD_LATENCY-1:0]   vld_sr_d;
    logic [c_INF_W-1:0]      w_inflight;
    logic [c_INF_W-1:0]      w_inflight_d;

    // FIFO
    logic [DATA_BITS-1:0]    mem_data_q [FIFO_DEPTH];
    logic                    mem_last_q [FIFO_DEPTH];
    logic [c_FIFO_AW-1:0]    wr_ptr_q;
    logic [c_FIFO_AW-1:0]    rd_ptr_q;
    logic [c_FCNT_W-1:0]     fifo_count_q;
    logic [ADDRESS_BITS:0]   push_idx_q;

    logic                    w_start_accept;
    logic [31:0]             w_outstanding;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_push_last;
    logic                    w_pop;
    logic                    w_fifo_nonempty;

    assign w_start_accept  = (state_q == S_IDLE) && bus.start;
    // Everything issued but not yet popped; bounding this by the FIFO depth
    // guarantees every returning word has a slot waiting for it.
    assign w_outstanding   = 32'(fifo_count_q) + 32'(w_inflight);
    assign w_issue         = (state_q == S_ISSUE) && (remaining_q != '0)
                             && (w_outstanding < 32'(FIFO_DEPTH));
    assign w_push          = vld_sr_q[RD_LATENCY-1];
    assign w_push_last     = (push_idx_q == (word_count_q - c_CNT_ONE));
    assign w_fifo_nonempty = (fifo_count_q != '0);
    assign w_pop           = w_fifo_nonempty && bus.m_ready;
    assign vld_sr_d        = (vld_sr_q << 1) | RD_LATENCY'(w_issue);

    // Words in flight now and after the coming edge (popcount of the pipeline)
    always_comb begin
        w_inflight   = '0;
        w_inflight_d = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight   = w_inflight   + c_INF_W'(vld_sr_q[i]);
            w_inflight_d = w_inflight_d + c_INF_W'(vld_sr_d[i]);
        end
    end

    // Run sequencer: state, address generation and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            word_count_q <= '0;
            next_addr_q  <= '0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        word_count_q <= bus.word_count;
                        remaining_q  <= bus.word_count;
                        next_addr_q  <= bus.base_addr;
                        if (bus.word_count == '0) begin
                            // Empty run completes straight away
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_ISSUE;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        addr_q      <= next_addr_q;
                        next_addr_q <= next_addr_q + c_ADDR_ONE;
                        remaining_q <= remaining_q - c_CNT_ONE;
                        if (remaining_q == c_CNT_ONE) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    rd_en_q <= (w_inflight_d != '0);
                    // Empty FIFO with nothing in flight means the last word
                    // has already been handshaked downstream.
                    if ((w_inflight == '0) && (fifo_count_q == '0)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Valid pipeline shift: a 1 enters on each issued address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
        end
    end

    // FIFO pointers, occupancy and sequence index of the next pushed word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            push_idx_q   <= '0;
        end else begin
            if (w_start_accept) begin
                push_idx_q <= '0;
            end else if (w_push) begin
                push_idx_q <= push_idx_q + c_CNT_ONE;
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   fifo_count_q <= fifo_count_q + c_FCNT_ONE;
                2'b01:   fifo_count_q <= fifo_count_q - c_FCNT_ONE;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // FIFO storage; no reset needed because the head is masked when empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_data_q[wr_ptr_q] <= bus.fifo_tx_data;
            mem_last_q[wr_ptr_q] <= w_push_last;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.start_rd_en   = rd_en_q;
    assign bus.address_input = addr_q;
    assign bus.m_valid       = w_fifo_nonempty;
    assign bus.m_data        = w_fifo_nonempty ? mem_data_q[rd_ptr_q] : '0;
    assign bus.m_last        = w_fifo_nonempty ? mem_last_q[rd_ptr_q] : 1'b0;

endmodule
`default_nettype wire

// File: doc/tx_data_buffer.md
# tx_data_buffer

Transmit-side data buffer between the BRAM read module and the TCP segment builder. On a start request it generates a run of consecutive BRAM word addresses for the read module and drives its read enable. It tags the returned 512-bit words through a fixed-latency valid pipeline and queues them in an internal FIFO. Words leave on a valid/ready stream with a last-word marker, and a credit check ensures the FIFO can never overflow.

## Interface
Parameters:
- DATA_BITS, 512, width of one BRAM word / stream beat
- ADDRESS_BITS, 10, BRAM word-address width
- FIFO_DEPTH, 16, internal FIFO entries (power of two, ≥ RD_LATENCY+1)
- RD_LATENCY, 3, cycles from address presented to data valid on fifo_tx_data

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request pulse, accepted only in IDLE
- base_addr  in  ADDRESS_BITS  first BRAM word address of the run
- word_count  in  ADDRESS_BITS+1  number of words, 0..2^ADDRESS_BITS
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the run is complete
- start_rd_en  out  1  read-module enable, high while issuing or words are in flight
- address_input  out  ADDRESS_BITS  BRAM word address to read module
- fifo_tx_data  in  DATA_BITS  word returned by read module
- m_data  out  DATA_BITS  output stream data (FIFO head)
- m_valid  out  1  m_data valid
- m_last  out  1  final word of the run, qualified by m_valid
- m_ready  in  1  downstream accepts when m_valid && m_ready

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start: latch base_addr and word_count, set busy.
  - If word_count = 0, go to DONE. Otherwise go to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - issue = (remaining > 0) && (fifo_count + inflight < FIFO_DEPTH).
  - Each issue cycle presents the next address, decrements remaining, and pushes 1 into the RD_LATENCY-deep valid shift register.
  - Addresses increment modulo 2^ADDRESS_BITS, so 1023 wraps to 0.
  - Go to DRAIN when the last address is issued.
- DRAIN: wait until inflight = 0, FIFO is empty, and the last word has been handshaked; then go to DONE.
- DONE: done = 1 for one cycle, busy clears, return to IDLE.
- Valid pipeline: when the valid bit exits the shift register, fifo_tx_data is pushed into the FIFO that same edge. inflight = popcount of the shift register.
- m_last is set on the pushed word whose sequence index = word_count-1.
- FIFO push and pop in the same cycle are both performed and the count is unchanged; this includes the case where the FIFO is full.
- The credit rule guarantees no push is ever lost. Overflow is a design error, and verification must assert it never occurs.
- start_rd_en = 1 in ISSUE, and in DRAIN while inflight > 0; otherwise 0.
- Counters and arithmetic:
  - remaining is ADDRESS_BITS+1 bits.
  - fifo_count is log2(FIFO_DEPTH)+1 bits.
  - inflight is log2(RD_LATENCY)+1 bits.

## Timing
- Reset values:
  - State IDLE.
  - busy, done, start_rd_en, m_valid, m_last = 0.
  - address_input = 0, m_data = 0.
  - FIFO empty, valid pipeline cleared.
- Reset asserted mid-run: everything clears immediately, in-flight and queued words are discarded, and no done pulse is generated.
- Start to first address: start sampled at edge N → ISSUE and first address_input/start_rd_en valid from edge N+1.
- Issue rate: with an uncongested FIFO, one address per cycle.
- Read return: the address presented in cycle K has its data sampled from fifo_tx_data at the edge ending cycle K+RD_LATENCY-1; it is written to the FIFO at that edge.
- m_valid rises the cycle after the first FIFO write. Minimum start-to-m_valid latency is RD_LATENCY+1 cycles.
- m_data, m_valid and m_last are held stable while m_valid && !m_ready.
- done is asserted the cycle after DRAIN exits. busy falls in the same cycle that done rises.
- Back-pressure: with m_ready held low, issuing stalls once fifo_count + inflight = FIFO_DEPTH and resumes one cycle after the next pop.

## Test plan
- **Basic run:** base_addr=0x010, word_count=4, m_ready=1, read model returns word = address → m_data 0x010..0x013 in order, m_last on 0x013, one done pulse, busy low afterwards.
- **Wrap-around:** base_addr=0x3FE, word_count=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001; data in matching order.
- **Back-pressure:** word_count=40, m_ready=0 for 50 cycles, then 1.
  - Issuing stops with exactly FIFO_DEPTH words queued or in flight.
  - No overflow.
  - All 40 words delivered in order, m_last on word 40.
- **Zero length:** word_count=0 → start_rd_en never rises, no m_valid, done one cycle after start.
- **Reset mid-run:** assert reset during word_count=20 with 5 words delivered → all outputs return to reset values immediately. A new run with base_addr=0x100, word_count=2 then completes cleanly.
- **Ignored start:** pulse start with different parameters during a busy run → the current run is unaffected and only one done pulse occurs.
